// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (responder) bridging the i2c_master register-access protocol onto
// a local 16-bit register bus. Handles pointer-write, data-write (MSB byte first) and
// pointer-read transactions. Open-drain SDA only; SCL is never driven (no clock stretching).
//
// Optional build: define I2C_TARGET_GLITCH_FILTER_EN to add a per-line filter after the
// synchronizers. A line then changes only after FILTER_LEN equal samples in a row.
//
// Ports:
//   clk        system clock (125 MHz)
//   reset_n    asynchronous active-low reset
//   scl_pin    I2C clock line, sampled only
//   sda_pin    I2C data line, driven 0 or released ('z)
//   reg_addr   register pointer for the current access
//   reg_wdata  write word {first byte, second byte}
//   reg_we     1-cycle write strobe
//   reg_re     1-cycle read request; reg_rdata is taken on the following cycle
//   reg_rdata  read word
//   busy       high from an address match until START/STOP/NACK
module i2c_target_regs #(
  parameter logic [6:0]  TARGET_ADDR     = 7'h48,
  parameter int unsigned SDA_HOLD_CYCLES = 38
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  , parameter int unsigned FILTER_LEN    = 4
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_pin,
  inout  wire         sda_pin,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  localparam int unsigned HW = $clog2(SDA_HOLD_CYCLES + 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWrHi, StWrHiAck, StWrLo, StWrLoAck,
    StRdHi, StRdHiAck, StRdLo, StRdLoAck, StIgnore
  } state_e;

  // Two-flop synchronizers; idle bus level is high.
  logic [1:0] scl_sync, sda_sync;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_pin};
      sda_sync <= {sda_sync[0], sda_pin};
    end
  end

  logic scl_f, sda_f;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] scl_cnt, sda_cnt;
  // Counter tracks how many consecutive samples disagree with the accepted level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
    end else begin
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  logic scl_prev, sda_prev;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

  state_e        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift, hi_byte;
  logic [15:0]   tx;
  logic          rw, ack_in, re_dly, inc_pend, sda_oe;
  logic [HW-1:0] hold_cnt;
  logic          drive_now;

  // SDA level to apply when the hold timer expires, judged from the post-fall state.
  always_comb begin
    drive_now = 1'b0;
    case (state)
      StAddrAck, StPtrAck, StWrHiAck, StWrLoAck: drive_now = 1'b1;
      StRdHi, StRdLo:                            drive_now = ~tx[15];
      default:                                   drive_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      bit_cnt   <= '0;
      shift     <= '0;
      hi_byte   <= '0;
      tx        <= '0;
      rw        <= 1'b0;
      ack_in    <= 1'b1;
      re_dly    <= 1'b0;
      inc_pend  <= 1'b0;
      sda_oe    <= 1'b0;
      hold_cnt  <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_dly <= reg_re;
      if (re_dly) tx <= reg_rdata;
      // Post-write increment lands the cycle after reg_we so the strobe sees the old pointer.
      if (inc_pend) begin
        reg_addr <= reg_addr + 8'd1;
        inc_pend <= 1'b0;
      end
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) sda_oe <= drive_now;
      end

      if (start_det || stop_det) begin
        state    <= start_det ? StAddr : StIdle;
        bit_cnt  <= '0;
        busy     <= 1'b0;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
      end else if (scl_rise) begin
        case (state)
          StAddr, StPtr, StWrHi, StWrLo: begin
            shift   <= {shift[6:0], sda_f};
            bit_cnt <= bit_cnt + 4'd1;
          end
          StRdHi, StRdLo: begin
            tx      <= {tx[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
          StRdHiAck, StRdLoAck: ack_in <= sda_f;
          default: ;
        endcase
      end else if (scl_fall) begin
        hold_cnt <= HW'(SDA_HOLD_CYCLES);
        case (state)
          StAddr: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            if (shift[7:1] == TARGET_ADDR) begin
              state <= StAddrAck;
              busy  <= 1'b1;
              rw    <= shift[0];
            end else begin
              state <= StIgnore;
            end
          end
          StAddrAck: begin
            if (rw) begin
              reg_re <= 1'b1;
              state  <= StRdHi;
            end else begin
              state  <= StPtr;
            end
          end
          StPtr: if (bit_cnt == 4'd8) begin
            bit_cnt  <= '0;
            reg_addr <= shift;
            state    <= StPtrAck;
          end
          StPtrAck:  state <= StWrHi;
          StWrHi: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            hi_byte <= shift;
            state   <= StWrHiAck;
          end
          StWrHiAck: state <= StWrLo;
          StWrLo: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            state   <= StWrLoAck;
          end
          StWrLoAck: begin
            reg_we    <= 1'b1;
            reg_wdata <= {hi_byte, shift};
            inc_pend  <= 1'b1;
            state     <= StWrHi;
          end
          StRdHi: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            state   <= StRdHiAck;
          end
          StRdHiAck: begin
            if (!ack_in) begin
              state <= StRdLo;
            end else begin
              state <= StIgnore;
              busy  <= 1'b0;
            end
          end
          StRdLo: if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            state   <= StRdLoAck;
          end
          StRdLoAck: begin
            if (!ack_in) begin
              reg_addr <= reg_addr + 8'd1;
              reg_re   <= 1'b1;
              state    <= StRdHi;
            end else begin
              state <= StIgnore;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_pin = sda_oe ? 1'b0 : 1'bz;

endmodule
